// File: rtl/mem_access_unit.sv
// mem_access_unit
// Turns single CPU byte, halfword and word load/store requests into accesses
// on a word-wide data memory. Each access takes one memory cycle. Sub-word
// stores are done as a read-modify-write within that single cycle, using the
// combinational memory read port.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   req, wr           access request (sampled only while ready=1); 1=store, 0=load
//   size, sext        00 byte, 01 halfword, 10 word, 11 illegal; sign-extend loads
//   addr, wdata       byte address; right-aligned store data
//   ready             idle and able to accept a request
//   done, err         completion pulse; err marks a rejected (misaligned/illegal) access
//   rdata             extended load result, held until the next load completes
//   mem_we, mem_addr  memory write enable; word index (addr[31:2])
//   mem_wd, mem_rd    full-word memory write data; combinational memory read data
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, EXEC, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic [1:0]          lane_q, lane_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_we_q, mem_we_d;

  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
  endfunction

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] sz,
                                                     input logic [1:0] lane,
                                                     input logic sx);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DATA_W-1:0]  r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = sx ? DATA_W'(b) : {24'd0, b};
      2'b01:   r = sx ? DATA_W'(h) : {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the current memory word.
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                     input logic [DATA_W-1:0] wd,
                                                     input logic [1:0] sz,
                                                     input logic [1:0] lane);
    logic [DATA_W-1:0] r;
    r = word;
    case (sz)
      2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    size_d     = size_q;
    sext_d     = sext_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mem_we_d   = 1'b0;
    case (state_q)
      // Accept: latch the whole request so later input changes cannot
      // disturb the access in flight.
      IDLE: begin
        ready_d = 1'b1;
        if (req) begin
          ready_d = 1'b0;
          wr_d    = wr;
          size_d  = size;
          sext_d  = sext;
          lane_d  = addr[1:0];
          wdata_d = wdata;
          if (is_illegal(size, addr[1:0])) begin
            // Rejected accesses never touch the memory port.
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = EXEC;
            mem_we_d   = wr;
            mem_addr_d = {2'b00, addr[31:2]};
          end
        end
      end
      // Memory cycle: capture load data at the end of EXEC.
      EXEC: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (!wr_q) rdata_d = load_extend(mem_rd, size_q, lane_q, sext_q);
      end
      DONE, ERR: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_we_q   <= mem_we_d;
    end
  end

  // Write data depends on mem_rd during EXEC, so it cannot be registered.
  // Outside a store's EXEC cycle it is held at zero.
  always_comb begin
    mem_wd = '0;
    if (state_q == EXEC && wr_q) mem_wd = store_merge(mem_rd, wdata_q, size_q, lane_q);
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;

endmodule
